// File: rtl/sb_tx_serializer_crc.sv
// Sideband TX back-end: serialises 10-bit framed symbols LSB-first onto sbtx and keeps a bit-serial CRC-16.
// Latency: trans is sampled on the load edge and sym[0] is on sbtx the next cycle; the symbol period is 10 cycles.
// Backpressure: none. The generator holds trans for 10 cycles; sym_done marks each stop bit / slot boundary.
module sb_tx_serializer_crc #(
    parameter int          SYM_W    = 10,
    parameter logic [15:0] CRC_INIT = 16'hFFFF,
    parameter logic [15:0] CRC_POLY = 16'h8005
) (
    input  logic             sb_clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] trans,
    input  logic [1:0]       trans_state,
    input  logic             crc_en,
    input  logic             sbtx_sel,
    output logic             sbtx,
    output logic [15:0]      crc_out,
    output logic             sym_done,
    output logic             tx_busy
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_IDLE  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    localparam logic [1:0] TS_DISC  = 2'd0;
    localparam logic [1:0] TS_START = 2'd2;

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0] shreg_q, shreg_d;
    logic             cov_q, cov_d;
    logic [15:0]      crc_q, crc_d;
    logic             crc_hi_sent_q, crc_hi_sent_d;
    logic             sbtx_q, sbtx_d;
    logic             sym_done_q, sym_done_d;
    logic             tx_busy_q, tx_busy_d;

    logic             is_start;
    logic             is_disc;
    logic             load;
    logic [7:0]       crc_byte;
    logic [SYM_W-1:0] load_sym;

    // One CRC-16 step for a single data bit, MSB-first register with the polynomial xored on feedback.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic fb;
        fb = c[15] ^ d;
        return {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    assign is_start = (trans_state == TS_START);
    assign is_disc  = (trans_state == TS_DISC);
    // Any code other than DISCONNECTED/START behaves as IDLE.
    assign crc_byte = crc_hi_sent_q ? crc_q[7:0] : crc_q[15:8];
    assign load_sym = sbtx_sel ? {1'b1, crc_byte, 1'b0} : trans;

    // State and datapath registers; reset forces the line low and re-seeds the CRC.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_OFF;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= '0;
            cov_q         <= 1'b0;
            crc_q         <= CRC_INIT;
            crc_hi_sent_q <= 1'b0;
            sbtx_q        <= 1'b0;
            sym_done_q    <= 1'b0;
            tx_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            cov_q         <= cov_d;
            crc_q         <= crc_d;
            crc_hi_sent_q <= crc_hi_sent_d;
            sbtx_q        <= sbtx_d;
            sym_done_q    <= sym_done_d;
            tx_busy_q     <= tx_busy_d;
        end
    end

    // Next-state logic: line level per state, shifting, CRC update, and symbol loading.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        cov_d         = cov_q;
        crc_d         = crc_q;
        crc_hi_sent_d = crc_hi_sent_q;
        sbtx_d        = sbtx_q;
        sym_done_d    = 1'b0;
        tx_busy_d     = tx_busy_q;
        load          = 1'b0;

        case (state_q)
            S_OFF: begin
                sbtx_d = 1'b0;
                if (is_start) begin
                    load = 1'b1;
                end else if (!is_disc) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (is_start) begin
                    load = 1'b1;
                end else begin
                    // Idle line is high; every new transaction starts from a fresh CRC.
                    sbtx_d        = 1'b1;
                    crc_d         = CRC_INIT;
                    crc_hi_sent_d = 1'b0;
                    if (is_disc) begin
                        state_d = S_OFF;
                    end
                end
            end

            S_SHIFT: begin
                if (bit_cnt_q == 4'd0) begin
                    // Slot boundary reached after a back-to-back request; only leaves if the
                    // generator withdrew START in the meantime.
                    if (is_start) begin
                        load = 1'b1;
                    end else if (is_disc) begin
                        state_d   = S_OFF;
                        sbtx_d    = 1'b0;
                        tx_busy_d = 1'b0;
                    end else begin
                        state_d   = S_IDLE;
                        sbtx_d    = 1'b1;
                        tx_busy_d = 1'b0;
                    end
                end else begin
                    sbtx_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    // Only the eight data bits feed the CRC; start and stop are framing.
                    if (cov_q && (bit_cnt_q <= 4'd8)) begin
                        crc_d = crc_step(crc_q, shreg_q[0]);
                    end
                    if (bit_cnt_q == 4'd9) begin
                        bit_cnt_d  = 4'd0;
                        sym_done_d = 1'b1;
                        if (is_disc) begin
                            state_d   = S_OFF;
                            tx_busy_d = 1'b0;
                        end else if (!is_start) begin
                            state_d   = S_IDLE;
                            tx_busy_d = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = S_OFF;
                sbtx_d  = 1'b0;
            end
        endcase

        // Load launches the start bit immediately; CRC slots never feed the CRC themselves.
        if (load) begin
            state_d   = S_SHIFT;
            sbtx_d    = load_sym[0];
            shreg_d   = load_sym >> 1;
            cov_d     = crc_en & ~sbtx_sel;
            bit_cnt_d = 4'd1;
            tx_busy_d = 1'b1;
            if (sbtx_sel) begin
                crc_hi_sent_d = ~crc_hi_sent_q;
            end
        end
    end

    assign sbtx     = sbtx_q;
    assign crc_out  = crc_q;
    assign sym_done = sym_done_q;
    assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_sb_tx_serializer_crc.sv
module tb_sb_tx_serializer_crc;

    localparam logic [1:0] ST_DISC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_START = 2'd2;

    logic        sb_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [9:0]  trans;
    logic [1:0]  trans_state;
    logic        crc_en;
    logic        sbtx_sel;
    logic        sbtx;
    logic [15:0] crc_out;
    logic        sym_done;
    logic        tx_busy;

    typedef struct packed {
        logic [9:0]  sym;
        logic [15:0] crc;
        logic [7:0]  gap;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    logic [9:0] hist  = '0;
    int         since = 0;

    sb_tx_serializer_crc dut (
        .sb_clk      (sb_clk),
        .rst         (rst),
        .trans       (trans),
        .trans_state (trans_state),
        .crc_en      (crc_en),
        .sbtx_sel    (sbtx_sel),
        .sbtx        (sbtx),
        .crc_out     (crc_out),
        .sym_done    (sym_done),
        .tx_busy     (tx_busy)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: collects the line LSB-first and compares a whole symbol on each sym_done.
    always @(negedge sb_clk) begin
        exp_t e;
        hist  = {sbtx, hist[9:1]};
        since = since + 1;
        if (sym_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sym_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sym_bits", {22'd0, hist}, {22'd0, e.sym});
                check("sym_crc", {16'd0, crc_out}, {16'd0, e.crc});
                if (e.gap != 8'd0) begin
                    check("sym_gap", since, {24'd0, e.gap});
                end
            end
            since = 0;
        end
    end

    // Drive one symbol slot starting at the next negedge; nxt is applied at negedge chg_at.
    // busy_mode: 0 no busy checks, 1 check in-symbol, 2 also check at the slot boundary.
    task automatic send(input logic [9:0] t, input logic en, input logic sel,
                        input logic [1:0] nxt, input int chg_at, input int busy_mode,
                        input logic [9:0] exp_sym, input logic [15:0] exp_crc, input logic [7:0] gap);
        exp_t e;
        @(negedge sb_clk);
        if (busy_mode == 2) check("busy_at_boundary", {31'd0, tx_busy}, 32'd1);
        trans_state = ST_START;
        trans       = t;
        crc_en      = en;
        sbtx_sel    = sel;
        e.sym = exp_sym;
        e.crc = exp_crc;
        e.gap = gap;
        exp_q.push_back(e);
        for (int i = 1; i <= 9; i++) begin
            @(negedge sb_clk);
            if (busy_mode != 0) check("busy_in_symbol", {31'd0, tx_busy}, 32'd1);
            if (i == chg_at) trans_state = nxt;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sb_clk);
            trans_state = ST_IDLE;
            crc_en      = 1'b0;
            sbtx_sel    = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        trans       = '0;
        trans_state = ST_DISC;
        crc_en      = 1'b0;
        sbtx_sel    = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_sbtx", {31'd0, sbtx}, 32'd0);
        check("rst_crc", {16'd0, crc_out}, 32'hFFFF);
        check("rst_sym_done", {31'd0, sym_done}, 32'd0);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);

        // OFF -> IDLE: line rises one cycle after IDLE is entered
        @(negedge sb_clk);
        trans_state = ST_IDLE;
        @(negedge sb_clk);
        rst = 1'b1;
        @(negedge sb_clk);
        check("off_to_idle_sbtx", {31'd0, sbtx}, 32'd0);
        @(negedge sb_clk);
        check("idle_sbtx", {31'd0, sbtx}, 32'd1);
        check("idle_crc", {16'd0, crc_out}, 32'hFFFF);
        check("idle_busy", {31'd0, tx_busy}, 32'd0);

        // Uncovered symbol with data FE: bits 0,0,1,1,1,1,1,1,1,1; CRC untouched
        send(10'h3FC, 1'b0, 1'b0, ST_IDLE, 9, 1, 10'h3FC, 16'hFFFF, 8'd0);
        idle(3);

        // Covered data 00 -> CRC FD02, then CRC high, low, and wrapped high byte
        send(10'h200, 1'b1, 1'b0, ST_START, 9, 0, 10'h200, 16'hFD02, 8'd0);
        send(10'h000, 1'b1, 1'b1, ST_START, 9, 0, 10'h3FA, 16'hFD02, 8'd0);
        send(10'h000, 1'b1, 1'b1, ST_START, 9, 0, 10'h204, 16'hFD02, 8'd0);
        send(10'h000, 1'b1, 1'b1, ST_IDLE,  9, 0, 10'h3FA, 16'hFD02, 8'd0);
        idle(3);
        check("crc_reinit_in_idle", {16'd0, crc_out}, 32'hFFFF);

        // Back-to-back 05, 4E: no gap bit, busy held across the boundary
        send(10'h20A, 1'b0, 1'b0, ST_START, 9, 1, 10'h20A, 16'hFFFF, 8'd0);
        send(10'h29C, 1'b0, 1'b0, ST_IDLE,  9, 2, 10'h29C, 16'hFFFF, 8'd10);
        idle(2);

        // START -> DISCONNECTED at bit 4: symbol completes, then line drops
        send(10'h34A, 1'b0, 1'b0, ST_DISC, 4, 1, 10'h34A, 16'hFFFF, 8'd0);
        @(negedge sb_clk);
        check("disc_busy_at_stop", {31'd0, tx_busy}, 32'd0);
        check("disc_stop_bit", {31'd0, sbtx}, 32'd1);
        @(negedge sb_clk);
        check("disc_sbtx_off", {31'd0, sbtx}, 32'd0);
        @(negedge sb_clk);
        check("disc_sbtx_stays_off", {31'd0, sbtx}, 32'd0);

        // Reset mid-symbol (load from OFF, data FF covered) at bit 6
        @(negedge sb_clk);
        trans_state = ST_START;
        trans       = 10'h3FE;
        crc_en      = 1'b1;
        sbtx_sel    = 1'b0;
        repeat (6) @(negedge sb_clk);
        check("mid_crc_5bits", {16'd0, crc_out}, 32'hFFE0);
        check("mid_busy", {31'd0, tx_busy}, 32'd1);
        check("mid_sbtx", {31'd0, sbtx}, 32'd1);
        rst = 1'b0;
        #1;
        check("arst_sbtx", {31'd0, sbtx}, 32'd0);
        check("arst_busy", {31'd0, tx_busy}, 32'd0);
        check("arst_crc", {16'd0, crc_out}, 32'hFFFF);
        check("arst_sym_done", {31'd0, sym_done}, 32'd0);
        trans_state = ST_IDLE;
        crc_en      = 1'b0;
        @(negedge sb_clk);
        rst = 1'b1;
        repeat (2) @(negedge sb_clk);
        check("post_rst_sbtx", {31'd0, sbtx}, 32'd1);
        check("post_rst_crc", {16'd0, crc_out}, 32'hFFFF);
        check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

        repeat (3) @(negedge sb_clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/sb_tx_serializer_crc.md
Name: sb_tx_serializer_crc

Overview:
- Sideband transmit back-end; sits directly downstream of the SB transaction generator.
- Takes the 10-bit framed symbols (trans, trans_state, crc_en, sbtx_sel) from the generator and shifts them out LSB-first onto the single-wire sbtx line at one bit per sb_clk.
- Computes the transaction CRC-16 bit-serially over payload data bits.
- Substitutes the CRC high and low bytes into the symbol stream when sbtx_sel is asserted.

Parameters:
- SYM_W, 10, symbol width: start bit at [0], 8 data bits at [8:1], stop bit at [9].
- CRC_INIT, 16'hFFFF, CRC register value at the start of each transaction.
- CRC_POLY, 16'h8005, CRC-16 polynomial x^16+x^15+x^2+1.

Ports:
- sb_clk, input, 1, sideband clock (one bit time per cycle).
- rst, input, 1, asynchronous, active-low reset.
- trans, input, SYM_W, framed symbol from the generator; stable for 10 cycles.
- trans_state, input, 2, 0=DISCONNECTED, 1=IDLE, 2=START; other codes are treated as IDLE.
- crc_en, input, 1, current symbol's data bits are covered by the CRC.
- sbtx_sel, input, 1, current symbol slot carries a CRC byte instead of trans.
- sbtx, output, 1, serial sideband line.
- crc_out, output, 16, running CRC register.
- sym_done, output, 1, one-cycle pulse on the cycle the stop bit is driven.
- tx_busy, output, 1, high while a symbol is being shifted.

Behaviour:
- Reset (rst=0, async): sbtx=0, crc_out=CRC_INIT, sym_done=0, tx_busy=0, bit_cnt=0, shreg=0, crc_hi_sent=0. FSM enters S_OFF.

FSM states: S_OFF, S_IDLE, S_SHIFT. All transitions happen on the rising edge of sb_clk.
- S_OFF: sbtx<=0.
  - trans_state==DISCONNECTED: stay.
  - trans_state==IDLE: go to S_IDLE.
  - trans_state==START: load (see load rule) and go to S_SHIFT.
- S_IDLE: sbtx<=1; crc<=CRC_INIT; crc_hi_sent<=0.
  - trans_state==START: load and go to S_SHIFT.
  - trans_state==DISCONNECTED: go to S_OFF.
- Load rule (edge where bit_cnt==0 and trans_state==START):
  - Symbol sym = sbtx_sel ? {1'b1, crc_byte, 1'b0} : trans.
  - crc_byte = crc_hi_sent ? crc[7:0] : crc[15:8]. When sbtx_sel=1, toggle crc_hi_sent.
  - sbtx<=sym[0]; shreg<=sym>>1; latch cov = crc_en & ~sbtx_sel; bit_cnt<=1; tx_busy<=1.
- S_SHIFT, each edge with bit_cnt in 1..9: sbtx<=shreg[0]; shreg<=shreg>>1; bit_cnt<=bit_cnt+1.
  - sym_done=1 while bit_cnt==9 (stop bit on the line).
- CRC update: on the edges with bit_cnt in 1..8 and cov=1 (data bits only; start and stop bits excluded), with d = the bit being launched:
  - fb = crc[15]^d
  - crc <= {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0)
- End of symbol, edge with bit_cnt==9 (bit_cnt<=0):
  - trans_state==START: immediately load the next symbol on the following edge (back-to-back, no gap bit).
  - trans_state==IDLE: go to S_IDLE, tx_busy<=0.
  - trans_state==DISCONNECTED: go to S_OFF, tx_busy<=0.
- Changes to trans_state mid-symbol are ignored; the symbol always completes all 10 bits.
- Latency: trans is sampled at the load edge; sym[0] appears on sbtx one cycle later. The symbol period is exactly 10 cycles.
- CRC bytes are transmitted high byte first, then low byte, LSB-first within each byte. crc is not modified during CRC symbols.
- A third consecutive sbtx_sel slot sends crc[15:8] again (crc_hi_sent wraps); no error is flagged.
- Reset asserted mid-symbol: immediate return to reset values; sbtx=0.

Test Plan:
- Reset, then trans_state=IDLE -> sbtx=1 from the cycle after S_IDLE entry; crc_out=16'hFFFF; tx_busy=0.
- trans_state=START, trans={1,8'hFE,0}, crc_en=0 -> sbtx over 10 cycles = 0,0,1,1,1,1,1,1,1,1; sym_done high only on the 10th; crc_out stays 16'hFFFF.
- One symbol with data 8'h00, crc_en=1 -> crc_out=16'hFD02 after the symbol. The next two slots with sbtx_sel=1 shift out bytes 8'hFD then 8'h02, each framed by start 0 and stop 1.
- Back-to-back START symbols 8'h05, 8'h4E -> 20 contiguous bits with no idle bit between stop and start; tx_busy held high throughout.
- trans_state changes START->DISCONNECTED at bit 4 -> remaining bits complete; sbtx=0 from the cycle after the stop bit; FSM in S_OFF.
- rst pulsed low at bit 6 -> sbtx=0 and tx_busy=0 immediately; after release with trans_state=IDLE -> sbtx=1 and crc_out=16'hFFFF.
